gan_serial_scheduler: RTL and testbench

GAN_SERIAL_SCHEDULER -- requirements
Module: gan_serial_scheduler

---
 rtl/gan_serial_scheduler.sv | 166 ++++++++++++++++
 tb/tb_gan_serial_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gan_serial_scheduler.sv
// rtl/gan_serial_scheduler.sv - frame loader, inference sequencer and result holder for gan_serial_top
module gan_serial_scheduler #(
  parameter int FRAME_BITS     = 784,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               host_bit,
  input  logic               host_bit_valid,
  output logic               host_bit_ready,
  output logic               core_pixel_bit,
  output logic               core_pixel_bit_valid,
  input  logic               core_pixel_bit_ready,
  input  logic               core_frame_ready,
  input  logic               core_busy,
  input  logic               core_done,
  output logic               core_start,
  input  logic signed [15:0] core_fake_score,
  input  logic signed [15:0] core_real_score,
  input  logic               core_fake_is_real,
  input  logic               core_real_is_real,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [15:0] res_fake_score,
  output logic signed [15:0] res_real_score,
  output logic [1:0]         res_flags,
  output logic [7:0]         res_frame_id,
  output logic               timeout_err,
  output logic [2:0]         sched_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_WAIT_FR = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_REPORT  = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  // One counter serves as bit counter in LOAD and as timeout counter in WAIT_FR/RUN;
  // those states never overlap and each entry clears it.
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = 0;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [15:0] fake_q, fake_d;
  logic signed [15:0] real_q, real_d;
  logic [1:0]         flags_q, flags_d;
  logic [7:0]         id_q, id_d;
  logic               terr_q, terr_d;

  logic in_load;
  logic in_err;
  logic xfer;

  assign in_load = (state_q == S_LOAD);
  assign in_err  = (state_q == S_ERROR);
  assign xfer    = in_load & host_bit_valid & core_pixel_bit_ready;

  // Pixel pass-through exists only while loading; results are blanked once in ERROR.
  assign core_pixel_bit       = in_load & host_bit;
  assign core_pixel_bit_valid = in_load & host_bit_valid;
  assign host_bit_ready       = in_load & core_pixel_bit_ready;
  assign core_start           = (state_q == S_START);
  assign res_valid            = (state_q == S_REPORT);
  assign res_fake_score       = in_err ? 16'sd0 : fake_q;
  assign res_real_score       = in_err ? 16'sd0 : real_q;
  assign res_flags            = in_err ? 2'b00 : flags_q;
  assign res_frame_id         = in_err ? 8'd0 : id_q;
  assign timeout_err          = terr_q;
  assign sched_state          = state_q;

  // Next-state, counter and result-capture decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fake_d  = fake_q;
    real_d  = real_q;
    flags_d = flags_q;
    id_d    = id_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (host_bit_valid) begin
          state_d = S_LOAD;
          cnt_d   = CNT_ZERO;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (cnt_q == LAST_BIT) begin
            state_d = S_WAIT_FR;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_WAIT_FR: begin
        if (core_frame_ready && !core_busy) begin
          state_d = S_START;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = S_ERROR;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_START: begin
        state_d = S_RUN;
        cnt_d   = CNT_ZERO;
      end
      S_RUN: begin
        if (core_done) begin
          state_d = S_REPORT;
          fake_d  = core_fake_score;
          real_d  = core_real_score;
          flags_d = {core_real_is_real, core_fake_is_real};
        end else if (cnt_q == LAST_WAIT) begin
          state_d = S_ERROR;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          state_d = S_IDLE;
          id_d    = id_q + 8'd1;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      fake_q  <= 16'sd0;
      real_q  <= 16'sd0;
      flags_q <= 2'b00;
      id_q    <= 8'd0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fake_q  <= fake_d;
      real_q  <= real_d;
      flags_q <= flags_d;
      id_q    <= id_d;
      terr_q  <= terr_d;
    end
  end

endmodule

// File: tb/tb_gan_serial_scheduler.sv
// tb/tb_gan_serial_scheduler.sv - self-checking bench for gan_serial_scheduler
`timescale 1ns/1ps
module tb_gan_serial_scheduler;
  localparam int FB = 784;
  localparam int TO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, host_bit, host_bit_valid, host_bit_ready;
  logic core_pixel_bit, core_pixel_bit_valid, core_pixel_bit_ready;
  logic core_frame_ready, core_busy, core_done, core_start;
  logic signed [15:0] core_fake_score, core_real_score;
  logic core_fake_is_real, core_real_is_real;
  logic res_valid, res_ready;
  logic signed [15:0] res_fake_score, res_real_score;
  logic [1:0] res_flags;
  logic [7:0] res_frame_id;
  logic timeout_err;
  logic [2:0] sched_state;

  gan_serial_scheduler #(.FRAME_BITS(FB), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .host_bit(host_bit), .host_bit_valid(host_bit_valid), .host_bit_ready(host_bit_ready),
    .core_pixel_bit(core_pixel_bit), .core_pixel_bit_valid(core_pixel_bit_valid),
    .core_pixel_bit_ready(core_pixel_bit_ready),
    .core_frame_ready(core_frame_ready), .core_busy(core_busy), .core_done(core_done),
    .core_start(core_start),
    .core_fake_score(core_fake_score), .core_real_score(core_real_score),
    .core_fake_is_real(core_fake_is_real), .core_real_is_real(core_real_is_real),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_fake_score(res_fake_score), .res_real_score(res_real_score),
    .res_flags(res_flags), .res_frame_id(res_frame_id),
    .timeout_err(timeout_err), .sched_state(sched_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pixel pattern the host streams out.
  function automatic bit pat(input int i);
    return ((i % 3) == 0) ^ (((i / 11) % 2) == 1);
  endfunction

  // Behavioural model: phase numbers are the state codes visible on sched_state.
  int m_phase = 0;
  int m_bits  = 0;
  int m_wait  = 0;
  int m_id    = 0;
  logic signed [15:0] m_fake = 0;
  logic signed [15:0] m_real = 0;
  logic [1:0] m_flags = 0;
  bit m_terr = 0;
  bit chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_bits <= 0; m_wait <= 0; m_id <= 0;
      m_fake <= 0; m_real <= 0; m_flags <= 0; m_terr <= 0;
      chk_en <= 1;
    end else begin
      case (m_phase)
        0: if (host_bit_valid) begin m_phase <= 1; m_bits <= 0; end
        1: if (host_bit_valid && core_pixel_bit_ready) begin
             if (m_bits + 1 == FB) begin m_phase <= 2; m_wait <= 0; end
             else m_bits <= m_bits + 1;
           end
        2: if (core_frame_ready && !core_busy) m_phase <= 3;
           else if (m_wait + 1 == TO) begin m_phase <= 6; m_terr <= 1; end
           else m_wait <= m_wait + 1;
        3: begin m_phase <= 4; m_wait <= 0; end
        4: if (core_done) begin
             m_phase <= 5;
             m_fake <= core_fake_score;
             m_real <= core_real_score;
             m_flags <= {core_real_is_real, core_fake_is_real};
           end else if (m_wait + 1 == TO) begin m_phase <= 6; m_terr <= 1; end
           else m_wait <= m_wait + 1;
        5: if (res_ready) begin m_phase <= 0; m_id <= (m_id + 1) % 256; end
        default: m_phase <= 6;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", sched_state, m_phase);
      check("core_start", core_start, m_phase == 3);
      check("res_valid", res_valid, m_phase == 5);
      check("host_bit_ready", host_bit_ready, (m_phase == 1) ? core_pixel_bit_ready : 1'b0);
      check("pix_valid", core_pixel_bit_valid, (m_phase == 1) ? host_bit_valid : 1'b0);
      check("pix_bit", core_pixel_bit, (m_phase == 1) ? host_bit : 1'b0);
      check("res_fake", res_fake_score, (m_phase == 6) ? 0 : m_fake);
      check("res_real", res_real_score, (m_phase == 6) ? 0 : m_real);
      check("res_flags", res_flags, (m_phase == 6) ? 0 : m_flags);
      check("res_frame_id", res_frame_id, (m_phase == 6) ? 0 : m_id);
      check("timeout_err", timeout_err, m_terr);
    end
  end

  // Core-side receiver and start-pulse counter.
  bit rx[$];
  int starts = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      if (core_pixel_bit_valid === 1'b1 && core_pixel_bit_ready === 1'b1) rx.push_back(core_pixel_bit);
      if (core_start === 1'b1) starts++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: no stalls; mode 1: core ready toggles every cycle and host leaves gaps.
  task automatic send(input int nbits, input int mode);
    int idx = 0;
    int cyc = 0;
    while (idx < nbits && cyc < 4000) begin
      host_bit_valid       = (mode == 1 && (cyc % 5) == 3) ? 1'b0 : 1'b1;
      host_bit             = pat(idx);
      core_pixel_bit_ready = (mode == 1) ? 1'((cyc % 2) == 1) : 1'b1;
      @(negedge clk);
      if (host_bit_valid && host_bit_ready) idx++;
      tick();
      cyc++;
    end
    host_bit_valid       = 1'b0;
    core_pixel_bit_ready = 1'b0;
    check("bits_sent", idx, nbits);
  endtask

  task automatic check_rx(input string name);
    int nbad = 0;
    check({name, "_count"}, rx.size(), FB);
    foreach (rx[i]) if (rx[i] != pat(i)) nbad++;
    check({name, "_bad_bits"}, nbad, 0);
    rx.delete();
  endtask

  initial begin
    rst = 1; host_bit = 0; host_bit_valid = 0; core_pixel_bit_ready = 0;
    core_frame_ready = 0; core_busy = 0; core_done = 0;
    core_fake_score = 0; core_real_score = 0; core_fake_is_real = 0; core_real_is_real = 0;
    res_ready = 0;
    tick(); tick();
    rst = 0;
    check("rst_state", sched_state, 0);
    check("rst_host_ready", host_bit_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_frame_id", res_frame_id, 0);
    check("rst_timeout_err", timeout_err, 0);

    // Spurious done while idle.
    core_done = 1; core_fake_score = 99;
    tick(); tick();
    check("idle_done_state", sched_state, 0);
    check("idle_done_res_valid", res_valid, 0);

    // Frame A: full rate, spurious done held through LOAD.
    send(FB, 0);
    core_done = 0;
    check_rx("frameA");
    check("frameA_wait_fr", sched_state, 2);
    check("frameA_no_start_yet", starts, 0);
    tick(); tick();
    core_frame_ready = 1; core_busy = 1;
    tick();
    check("busy_blocks_start", sched_state, 2);
    core_busy = 0;
    tick();
    check("start_state", sched_state, 3);
    check("start_pulse", core_start, 1);
    core_frame_ready = 0; core_done = 1; core_fake_score = 77;
    tick();
    core_done = 0;
    check("run_after_start", sched_state, 4);
    check("start_done_ignored", res_valid, 0);
    tick(); tick(); tick();
    core_fake_score = -12; core_real_score = 300;
    core_real_is_real = 1; core_fake_is_real = 0; core_done = 1;
    tick();
    core_done = 0; core_fake_score = 5; core_real_score = 6;
    core_real_is_real = 0; core_fake_is_real = 1;
    check("report_valid", res_valid, 1);
    check("report_fake", res_fake_score, -12);
    check("report_real", res_real_score, 300);
    check("report_flags", res_flags, 2);
    check("report_id0", res_frame_id, 0);
    repeat (5) tick();
    check("held_valid", res_valid, 1);
    check("held_fake", res_fake_score, -12);
    check("held_real", res_real_score, 300);
    res_ready = 1;
    tick();
    res_ready = 0;
    check("accept_idle", sched_state, 0);
    check("accept_id1", res_frame_id, 1);
    check("one_start_pulse", starts, 1);

    // Frame B: backpressure and host gaps.
    send(FB, 1);
    check_rx("frameB");
    core_frame_ready = 1;
    tick();
    core_frame_ready = 0;
    tick();
    core_fake_score = 1000; core_real_score = -5; core_real_is_real = 1; core_fake_is_real = 1;
    core_done = 1;
    tick();
    core_done = 0; res_ready = 1;
    tick();
    res_ready = 0;
    check("frameB_id2", res_frame_id, 2);
    check("frameB_flags", res_flags, 3);

    // Reset in the middle of a frame, then a complete frame.
    send(400, 0);
    check("partial_rx", rx.size(), 400);
    rst = 1;
    tick();
    rst = 0;
    rx.delete();
    starts = 0;
    check("midload_rst_state", sched_state, 0);
    check("midload_rst_ready", host_bit_ready, 0);
    check("midload_rst_id", res_frame_id, 0);
    check("midload_rst_fake", res_fake_score, 0);
    send(FB, 0);
    check_rx("frameC");
    check("frameC_wait_fr", sched_state, 2);
    check("frameC_no_start", starts, 0);
    core_frame_ready = 1;
    tick();
    core_frame_ready = 0;
    check("frameC_start", sched_state, 3);
    tick();
    check("frameC_run", sched_state, 4);
    repeat (TO - 1) tick();
    check("run_before_timeout", sched_state, 4);
    tick();
    check("timeout_state", sched_state, 6);
    check("timeout_flag", timeout_err, 1);

    // ERROR ignores everything.
    host_bit_valid = 1; res_ready = 1; core_done = 1; core_frame_ready = 1; core_pixel_bit_ready = 1;
    repeat (5) tick();
    check("error_sticky_state", sched_state, 6);
    check("error_host_ready", host_bit_ready, 0);
    check("error_flag_sticky", timeout_err, 1);
    host_bit_valid = 0; res_ready = 0; core_done = 0; core_frame_ready = 0; core_pixel_bit_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    check("error_rst_state", sched_state, 0);
    check("error_rst_flag", timeout_err, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
